// File: rtl/agc_pack.sv
// AGC re-pack: rebuilds absolute per-channel AGC words from base + shift and
// re-attaches them, symbol-framed, to the 8-lane IQ stream with 2-cycle latency.
module agc_pack #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned SYMB_BEATS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [7:0]            i_fft_agc_base,
  input  logic [LANES*32-1:0]   i_fft_agc_shift,
  input  logic                  i_agc_vld,
  input  logic [LANES*64-1:0]   i_rx_data,
  input  logic [LANES*7-1:0]    i_rx_addr,
  input  logic [LANES-1:0]      i_rx_last,
  input  logic                  i_rx_vld,
  output logic [LANES*64-1:0]   o_cpri_data,
  output logic [LANES*7-1:0]    o_cpri_addr,
  output logic [LANES-1:0]      o_cpri_last,
  output logic [LANES-1:0]      o_rvalid,
  output logic [LANES*32-1:0]   o_fft_agc,
  output logic [LANES-1:0]      o_symb_eop,
  output logic [3:0]            o_status
);

  localparam logic [7:0] BEATS8 = 8'(SYMB_BEATS);
  localparam logic [6:0] BEATS7 = 7'(SYMB_BEATS);

  typedef enum logic [1:0] {IDLE, ARMED, STREAM} state_e;

  state_e                state_q, state_d;
  logic                  shadow_full_q, shadow_full_d;
  logic [LANES*32-1:0]   shadow_q, active_q, agc_new;
  logic [6:0]            cnt_q, cnt_d;
  logic [7:0]            cnt_inc;
  logic [3:0]            status_q;
  logic [8:0]            sum;
  logic                  sat_any, promote, first, miss, overrun, len_err;

  logic [LANES*64-1:0]   s1_data_q, out_data_q;
  logic [LANES*7-1:0]    s1_addr_q, out_addr_q;
  logic [LANES-1:0]      s1_last_q, out_last_q, out_vld_q, out_eop_q;
  logic                  s1_vld_q, s1_first_q;
  logic [LANES*32-1:0]   agc_out_q;

  always_comb begin
    agc_new = '0;
    sat_any = 1'b0;
    sum     = '0;
    for (int unsigned k = 0; k < LANES*4; k++) begin
      sum = {1'b0, i_fft_agc_base} + {1'b0, i_fft_agc_shift[k*8 +: 8]};
      agc_new[k*8 +: 8] = sum[8] ? 8'hFF : sum[7:0];
      sat_any = sat_any | sum[8];
    end
  end

  // A strobe coinciding with the promoting beat refills the freed shadow,
  // so it is not an overrun.
  always_comb begin
    promote       = i_rx_vld && (state_q == ARMED);
    first         = i_rx_vld && (state_q != STREAM);
    miss          = i_rx_vld && (state_q == IDLE);
    overrun       = i_agc_vld && shadow_full_q && !promote;
    shadow_full_d = i_agc_vld || (shadow_full_q && !promote);

    state_d = state_q;
    if (i_rx_vld) begin
      if (i_rx_last[0]) state_d = shadow_full_d ? ARMED : IDLE;
      else              state_d = STREAM;
    end else if (state_q == IDLE && i_agc_vld) begin
      state_d = ARMED;
    end

    cnt_inc = {1'b0, cnt_q} + 8'd1;
    cnt_d   = cnt_q;
    len_err = 1'b0;
    if (i_rx_vld) begin
      if (i_rx_last[0]) begin
        cnt_d   = '0;
        len_err = (cnt_inc != BEATS8);
      end else if (cnt_inc >= BEATS8) begin
        cnt_d   = BEATS7;
        len_err = 1'b1;
      end else begin
        cnt_d = cnt_inc[6:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      shadow_full_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '1;
      cnt_q         <= '0;
      status_q      <= '0;
      s1_data_q     <= '0;
      s1_addr_q     <= '0;
      s1_last_q     <= '0;
      s1_vld_q      <= 1'b0;
      s1_first_q    <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      out_last_q    <= '0;
      out_vld_q     <= '0;
      out_eop_q     <= '0;
      agc_out_q     <= '1;
    end else begin
      state_q       <= state_d;
      shadow_full_q <= shadow_full_d;
      if (i_agc_vld) shadow_q <= agc_new;
      if (promote)   active_q <= shadow_q;
      cnt_q         <= cnt_d;
      status_q      <= status_q | {len_err, overrun, miss, i_agc_vld & sat_any};
      s1_data_q     <= i_rx_data;
      s1_addr_q     <= i_rx_addr;
      s1_last_q     <= i_rx_last;
      s1_vld_q      <= i_rx_vld;
      s1_first_q    <= first;
      out_data_q    <= s1_data_q;
      out_addr_q    <= s1_addr_q;
      out_last_q    <= s1_last_q;
      out_vld_q     <= {LANES{s1_vld_q}};
      out_eop_q     <= {LANES{s1_vld_q & s1_last_q[0]}};
      if (s1_vld_q && s1_first_q) agc_out_q <= active_q;
    end
  end

  assign o_cpri_data = out_data_q;
  assign o_cpri_addr = out_addr_q;
  assign o_cpri_last = out_last_q;
  assign o_rvalid    = out_vld_q;
  assign o_symb_eop  = out_eop_q;
  assign o_fft_agc   = agc_out_q;
  assign o_status    = status_q;

endmodule

// File: tb/tb_agc_pack.sv
// Directed-sequence bench for agc_pack with random payload, checked against a
// symbol-level reference model of AGC banking, framing and status rules.
module tb_agc_pack;

  localparam int SB = 32;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic [7:0]   i_fft_agc_base;
  logic [255:0] i_fft_agc_shift;
  logic         i_agc_vld;
  logic [511:0] i_rx_data;
  logic [55:0]  i_rx_addr;
  logic [7:0]   i_rx_last;
  logic         i_rx_vld;
  logic [511:0] o_cpri_data;
  logic [55:0]  o_cpri_addr;
  logic [7:0]   o_cpri_last;
  logic [7:0]   o_rvalid;
  logic [255:0] o_fft_agc;
  logic [7:0]   o_symb_eop;
  logic [3:0]   o_status;

  agc_pack #(.LANES(8), .SYMB_BEATS(SB)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_fft_agc_base(i_fft_agc_base), .i_fft_agc_shift(i_fft_agc_shift),
    .i_agc_vld(i_agc_vld), .i_rx_data(i_rx_data), .i_rx_addr(i_rx_addr),
    .i_rx_last(i_rx_last), .i_rx_vld(i_rx_vld),
    .o_cpri_data(o_cpri_data), .o_cpri_addr(o_cpri_addr),
    .o_cpri_last(o_cpri_last), .o_rvalid(o_rvalid), .o_fft_agc(o_fft_agc),
    .o_symb_eop(o_symb_eop), .o_status(o_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           rst;
    bit           first;
    logic [511:0] data;
    logic [55:0]  addr;
    logic [7:0]   last;
    logic [255:0] agc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  bit           m_full = 0, m_insym = 0;
  int           m_cnt = 0;
  logic [255:0] m_shadow = '0, m_active = '1, exp_agc_out = '1;
  logic [3:0]   exp_status = '0;

  function automatic logic [255:0] agc_of(input logic [7:0] b, input logic [255:0] sh);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) begin
      int unsigned s = int'(b) + int'(sh[k*8 +: 8]);
      r[k*8 +: 8] = (s > 255) ? 8'hFF : 8'(s);
    end
    return r;
  endfunction

  function automatic bit sat_of(input logic [7:0] b, input logic [255:0] sh);
    bit r = 0;
    for (int k = 0; k < 32; k++)
      if (int'(b) + int'(sh[k*8 +: 8]) > 255) r = 1;
    return r;
  endfunction

  function automatic logic [255:0] rnd_sh(input int unsigned mx);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = 8'($urandom_range(mx, 0));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check what the DUT shows now, then apply inputs for the next edge
  // and advance the reference model by the rules for those inputs.
  task automatic step(input bit rstn, input bit av, input logic [7:0] base,
                      input logic [255:0] sh, input bit bv, input bit lst);
    exp_t e, n;
    bit have, promote;
    logic [511:0] d;
    logic [55:0]  a;
    @(negedge clk);
    cyc++;
    have = 0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      have = 1;
    end
    if (have && e.rst) begin
      exp_agc_out = '1;
      chk("rst_rvalid", o_rvalid, 0);
      chk("rst_data", o_cpri_data, 0);
      chk("rst_addr", o_cpri_addr, 0);
      chk("rst_last", o_cpri_last, 0);
      chk("rst_eop", o_symb_eop, 0);
    end else if (have) begin
      if (e.first) exp_agc_out = e.agc;
      chk("rvalid", o_rvalid, 8'hFF);
      chk("data", o_cpri_data, e.data);
      chk("addr", o_cpri_addr, e.addr);
      chk("last", o_cpri_last, e.last);
      chk("eop", o_symb_eop, {8{e.last[0]}});
    end else begin
      chk("idle_rvalid", o_rvalid, 0);
      chk("idle_eop", o_symb_eop, 0);
    end
    chk("agc", o_fft_agc, exp_agc_out);
    chk("status", o_status, exp_status);

    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    a[31:0]  = $urandom();
    a[55:32] = 24'($urandom());
    i_reset_n       = rstn;
    i_agc_vld       = av;
    i_fft_agc_base  = base;
    i_fft_agc_shift = sh;
    i_rx_vld        = bv;
    i_rx_data       = d;
    i_rx_addr       = a;
    i_rx_last       = {7'($urandom()), lst};

    if (!rstn) begin
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      n = '{cyc: cyc + 1, rst: 1'b1, first: 1'b0, data: '0, addr: '0, last: '0, agc: '0};
      q.push_back(n);
      m_full = 0; m_insym = 0; m_cnt = 0; m_active = '1; exp_status = '0;
    end else begin
      promote = bv && !m_insym && m_full;
      if (bv && !m_insym && !m_full) exp_status[1] = 1'b1;
      if (promote) begin
        m_active = m_shadow;
        m_full   = 0;
      end
      if (av) begin
        if (m_full) exp_status[2] = 1'b1;
        if (sat_of(base, sh)) exp_status[0] = 1'b1;
        m_shadow = agc_of(base, sh);
        m_full   = 1;
      end
      if (bv) begin
        n = '{cyc: cyc + 2, rst: 1'b0, first: !m_insym, data: d, addr: a,
              last: i_rx_last, agc: m_active};
        q.push_back(n);
        m_cnt++;
        if (lst) begin
          if (m_cnt != SB) exp_status[3] = 1'b1;
          m_cnt   = 0;
          m_insym = 0;
        end else begin
          if (m_cnt >= SB) begin
            exp_status[3] = 1'b1;
            m_cnt = SB;
          end
          m_insym = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, '0, 0, 0);
  endtask

  task automatic strobe(input logic [7:0] b, input logic [255:0] sh);
    step(1, 1, b, sh, 0, 0);
  endtask

  task automatic sym(input int nb, input int strobe_at, input logic [7:0] sb,
                     input logic [255:0] ss, input int rst_at, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(2, 0) == 0) step(1, 0, 8'h00, '0, 0, 0);
      step(i != rst_at, i == strobe_at, sb, ss, 1, i == nb - 1);
    end
  endtask

  logic [255:0] s1, s2, s3;

  initial begin
    i_reset_n = 0; i_agc_vld = 0; i_fft_agc_base = '0; i_fft_agc_shift = '0;
    i_rx_vld = 0; i_rx_data = '0; i_rx_addr = '0; i_rx_last = '0;
    repeat (2) @(posedge clk);
    repeat (3) step(0, 0, 8'h00, '0, 0, 0);
    chk("reset_agc", o_fft_agc, {32{8'hFF}});
    chk("reset_status", o_status, 0);
    chk("reset_rvalid", o_rvalid, 0);

    // nominal symbol
    strobe(8'h10, {32{8'h03}});
    idle(1);
    sym(32, -1, 8'h00, '0, -1, 0);
    idle(3);
    chk("nom_agc", o_fft_agc, {32{8'h13}});
    chk("nom_status", o_status, 0);

    // back-to-back symbols, second strobe mid-symbol A
    s1 = rnd_sh(8'h7F); s2 = rnd_sh(8'h7F);
    strobe(8'h10, s1);
    sym(32, 10, 8'h20, s2, -1, 0);
    sym(32, -1, 8'h00, '0, -1, 0);
    idle(3);
    chk("b2b_agc", o_fft_agc, agc_of(8'h20, s2));
    chk("b2b_no_overrun", o_status[2], 1'b0);

    // strobe on the same cycle as the promoting first beat
    s1 = rnd_sh(8'h7F); s2 = rnd_sh(8'h7F);
    strobe(8'h05, s1);
    idle(2);
    sym(32, 0, 8'h50, s2, -1, 1);
    sym(32, -1, 8'h00, '0, -1, 0);
    idle(3);
    chk("simul_agc", o_fft_agc, agc_of(8'h50, s2));
    chk("simul_status", o_status, 0);

    // saturation
    s3 = rnd_sh(8'h0F);
    s3[(2*4+1)*8 +: 8] = 8'h20;
    strobe(8'hF0, s3);
    idle(1);
    sym(32, -1, 8'h00, '0, -1, 1);
    idle(3);
    chk("sat_byte", o_fft_agc[72 +: 8], 8'hFF);
    chk("sat_other", o_fft_agc[7:0], 8'hF0 + s3[7:0]);
    chk("sat_flag", o_status[0], 1'b1);

    // overrun then miss
    s1 = rnd_sh(8'h7F); s2 = rnd_sh(8'h7F);
    strobe(8'h30, s1);
    idle(1);
    strobe(8'h40, s2);
    idle(1);
    sym(32, -1, 8'h00, '0, -1, 0);
    sym(32, -1, 8'h00, '0, -1, 0);
    idle(3);
    chk("ovr_agc", o_fft_agc, agc_of(8'h40, s2));
    chk("ovr_flag", o_status[2], 1'b1);
    chk("miss_flag", o_status[1], 1'b1);

    // length errors: short symbol, then one running past SYMB_BEATS
    strobe(8'h11, rnd_sh(8'h7F));
    sym(20, -1, 8'h00, '0, -1, 0);
    idle(3);
    chk("len_flag", o_status[3], 1'b1);
    sym(36, -1, 8'h00, '0, -1, 0);
    idle(3);

    // reset mid-symbol
    strobe(8'h22, rnd_sh(8'h7F));
    idle(1);
    sym(32, -1, 8'h00, '0, 10, 0);
    idle(3);
    chk("rstmid_miss", o_status[1], 1'b1);
    chk("rstmid_agc", o_fft_agc, {32{8'hFF}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
